// File: rtl/wm8731_i2s_dac_tx_pkg.sv
// Shared constants for the WM8731 I2S DAC transmitter: FSM encoding,
// default geometry and the optional underrun counter width.
package wm8731_i2s_dac_tx_pkg;

    // FSM state encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Default geometry: BCLK = iCLK / 32, 16-bit slots, 1024-cycle frame
    localparam int unsigned BCLK_HALF_DEF = 16;
    localparam int unsigned SLOT_W_DEF    = 16;

    // Width of the saturating underrun counter
    localparam int unsigned UNDERRUN_CNT_W = 8;

endpackage

// File: rtl/wm8731_i2s_dac_tx_i2s_bclk_gen.sv
// Bit-clock generator: free-running divider that toggles bclk on each terminal
// count. rise_stb/fall_stb are high in the cycle before bclk rises/falls, so
// registers updated on the strobe change exactly with the bclk edge.
// A synchronous clear parks bclk low with the divider at zero; the first
// toggle after clear is therefore always a rise.
module wm8731_i2s_dac_tx_i2s_bclk_gen
    import wm8731_i2s_dac_tx_pkg::*;
#(
    parameter int unsigned BCLK_HALF = BCLK_HALF_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);

    logic [DW-1:0] div_q;
    logic          bclk_q;
    logic          tc;

    assign tc = !clr && (div_q == DIV_LAST);

    // Divider and bclk register, held at zero while cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (clr) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else if (tc) begin
            div_q  <= '0;
            bclk_q <= ~bclk_q;
        end else begin
            div_q  <= div_q + DW'(1);
        end
    end

    assign bclk     = bclk_q;
    assign rise_stb = tc && !bclk_q;
    assign fall_stb = tc && bclk_q;

endmodule

// File: rtl/wm8731_i2s_dac_tx.sv
// I2S (Philips) master transmitter for the WM8731 DAC path.
// iEN is the codec configuration-done flag: nothing toggles towards the codec
// until it is high, and dropping it aborts the current frame at once.
// Stereo samples arrive over valid/ready into a one-entry holding register;
// each frame boundary moves the held word into the shift register, or sends
// zeros and pulses oUNDERRUN when nothing is held.
// Optional: define I2S_TX_UNDERRUN_CNT_EN to add the saturating 8-bit
// oUNDERRUN_CNT output (cleared on every IDLE->RUN transition).
module wm8731_i2s_dac_tx
    import wm8731_i2s_dac_tx_pkg::*;
#(
    parameter int unsigned BCLK_HALF = BCLK_HALF_DEF,
    parameter int unsigned SLOT_W    = SLOT_W_DEF
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iEN,
    input  logic              iSMP_VALID,
    output logic              oSMP_READY,
    input  logic [SLOT_W-1:0] iSMP_L,
    input  logic [SLOT_W-1:0] iSMP_R,
    output logic              oBCLK,
    output logic              oDACLRCK,
    output logic              oDACDAT,
    output logic              oUNDERRUN
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] oUNDERRUN_CNT
`endif
);

    localparam int unsigned FW = 2 * SLOT_W;
    localparam int unsigned CW = $clog2(FW);
    localparam logic [CW-1:0] BIT_LAST = CW'(FW - 1);
    localparam logic [CW-1:0] BIT_RIGHT = CW'(SLOT_W);

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [CW-1:0] bit_cnt_q;
    logic [CW-1:0] bit_cnt_inc;
    logic          lrck_q;
    logic          dat_q;
    logic [FW-1:0] shift_q;
    logic [FW-1:0] hold_q;
    logic          hold_full_q;
    logic          underrun_q;

    logic bclk;
    logic fall_stb;
    logic rise_stb_unused;  // data launches on falls only
    logic bclk_clr;
    logic start;
    logic run;
    logic wrap;
    logic xfer;

    assign start    = (state_q == IDLE) && iEN;
    assign run      = (state_q == RUN) && iEN;
    assign bclk_clr = !run;
    assign wrap     = run && fall_stb && (bit_cnt_q == BIT_LAST);

    // Ready is gated by iEN so a sample is never accepted in the abort cycle
    assign oSMP_READY = run && !hold_full_q;
    assign xfer       = iSMP_VALID && oSMP_READY;

    wm8731_i2s_dac_tx_i2s_bclk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_bclk_gen (
        .clk      (iCLK),
        .rst_n    (iRST_N),
        .clr      (bclk_clr),
        .bclk     (bclk),
        .rise_stb (rise_stb_unused),
        .fall_stb (fall_stb)
    );

    // Next FSM state: run while enabled, abort as soon as enable drops
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iEN)  state_d = RUN;
            RUN:     if (!iEN) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Bit count after the coming BCLK fall
    always_comb begin
        bit_cnt_inc = wrap ? '0 : bit_cnt_q + CW'(1);
    end

    // Serialiser: bit counter, LRCK and DACDAT all move on BCLK falls; the
    // shift register reloads at the wrap so slot 0 still carries the old R LSB
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bit_cnt_q <= '0;
            lrck_q    <= 1'b0;
            dat_q     <= 1'b0;
            shift_q   <= '0;
        end else if (!run) begin
            // Also covers the entry boundary: zeros loaded, counter at slot 0
            bit_cnt_q <= '0;
            lrck_q    <= 1'b0;
            dat_q     <= 1'b0;
            shift_q   <= '0;
        end else if (fall_stb) begin
            bit_cnt_q <= bit_cnt_inc;
            lrck_q    <= (bit_cnt_inc >= BIT_RIGHT);
            dat_q     <= shift_q[FW-1];
            if (wrap) shift_q <= hold_full_q ? hold_q : '0;
            else      shift_q <= shift_q << 1;
        end
    end

    // Holding register: drained at a frame boundary, filled by a transfer;
    // a transfer on the boundary cycle lands after the load (no bypass)
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (!run) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (wrap && hold_full_q) begin
            hold_full_q <= 1'b0;
        end else if (xfer) begin
            hold_q      <= {iSMP_L, iSMP_R};
            hold_full_q <= 1'b1;
        end
    end

    // Underrun pulse in the first cycle of a frame that started empty
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) underrun_q <= 1'b0;
        else         underrun_q <= start || (wrap && !hold_full_q);
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_W-1:0] ucnt_q;

    // Saturating underrun counter, restarted on each run entry
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)                      ucnt_q <= '0;
        else if (start)                   ucnt_q <= '0;
        else if (underrun_q && ucnt_q != '1) ucnt_q <= ucnt_q + UNDERRUN_CNT_W'(1);
    end

    assign oUNDERRUN_CNT = ucnt_q;
`endif

    assign oBCLK     = bclk;
    assign oDACLRCK  = lrck_q;
    assign oDACDAT   = dat_q;
    assign oUNDERRUN = underrun_q;

endmodule
